scan_extreme_engine: RTL and testbench
======================================

// Module: scan_extreme_engine
// PURPOSE
//  Parametrised successor to the findMax datapath: scans N consecutive words of a synchronous
//  block RAM from startaddr and reports the extreme value (max or min, signed or unsigned) and
//  its address. Adds a start/done handshake, a configurable RAM read latency, address
//  wrap-around and an empty-scan flag. Sits between control logic and a blk_mem_gen read port.
// PARAMETERS
//  DATA_W   16  width of memory words / result
//  ADDR_W   8   width of address, n, and result_idx
//  RD_LAT   1   RAM read latency in cycles (1..4); addra issued in cycle k -> douta valid in k+RD_LAT
// PORTS
//  mclk        in   1        clock, all logic on rising edge
//  reset       in   1        synchronous, active-low reset (sampled on mclk)
//  start       in   1        pulse: begin scan; sampled only in IDLE
//  startaddr   in   ADDR_W   first address; latched on accepted start
//  n           in   ADDR_W   word count (0..2^ADDR_W-1); latched on accepted start
//  mode_min    in   1        0=find max, 1=find min; latched on accepted start
//  is_signed   in   1        1=two's-complement compare; latched on accepted start
//  addra       out  ADDR_W   RAM address
//  ena         out  1        RAM read enable, high only in cycles issuing a valid address
//  douta       in   DATA_W   RAM read data
//  busy        out  1        high from cycle after accepted start until done
//  done        out  1        one-cycle pulse when results are final
//  result      out  DATA_W   extreme value; held until next accepted start
//  result_idx  out  ADDR_W   address of extreme value; held until next accepted start
//  empty       out  1        1 if last scan had n==0 (result/result_idx then 0)
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE; addra=0, ena=0, busy=0, done=0, result=0,
//   result_idx=0, empty=0; in-flight tags cleared. Reset mid-scan aborts; no done pulse.
//  States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE: start=1 -> latch inputs; n==0 -> DONE (empty=1), else ISSUE. start=0 -> stay.
//   ISSUE: one address per cycle, ena=1, addra = startaddr+i mod 2^ADDR_W, i=0..n-1;
//    after the n-th address -> DRAIN.
//   DRAIN: ena=0; wait until all RD_LAT in-flight words sampled -> DONE.
//   DONE: done=1 for exactly one cycle, busy drops to 0 the same cycle -> IDLE.
//  Latency: start sampled in cycle 0; addresses in cycles 1..n; last data sampled in cycle
//   n+RD_LAT; done in cycle n+RD_LAT+1. n==0: done in cycle 1.
//  Tracking: RD_LAT-deep shift register of {valid, addr} tags aligns douta with its address.
//  First returned word loads the accumulator unconditionally; later words replace it only on
//   strict improvement (> for max, < for min), so ties keep the lowest-index occurrence.
//  Compare is signed or unsigned per latched is_signed; result is the raw DATA_W word.
//  Wrap: address counter is ADDR_W bits and wraps 2^ADDR_W-1 -> 0 silently;
//   result_idx reports the wrapped address.
//  start while busy or in DONE is ignored (no queueing). Input changes after acceptance have no effect.
//  result/result_idx/empty update only in the DONE cycle, stay stable otherwise.
// STRUCTURE
//  Shared header scan_defs.vh: state encodings (S_IDLE, S_ISSUE, S_DRAIN, S_DONE),
//   MODE_MAX/MODE_MIN constants.
//  One sub-module: extreme_cmp (combinational: a, b, mode_min, is_signed -> take_b).
//   FSM, address counter, tag pipeline and accumulator stay in scan_extreme_engine.
// TESTING
//  RAM init addr 0..7 = 5,9,3,9,1,16'h8000,7,2; addr 254,255 = 16'h0011,16'h0F00; RD_LAT=1 and 2.
//  1 start,addr=0,n=2,max,unsigned -> result=9, idx=1; done exactly in cycle n+RD_LAT+1.
//  2 addr=1,n=3,max (tie 9 at 1 and 3) -> result=9, idx=1.
//  3 addr=3,n=4: unsigned max -> 16'h8000,idx=5; signed max -> 9,idx=3; signed min -> 16'h8000,idx=5.
//  4 addr=254,n=4,max -> addra sequence 254,255,0,1; result=16'h0F00, idx=255.
//  5 n=0 -> done in cycle 1, empty=1, result=0; start pulsed while busy -> ignored, one done only.
//  6 reset=0 mid-ISSUE -> next cycle all outputs at reset values; new scan afterwards correct.

Source files
------------

// File: rtl/scan_extreme_engine_pkg.sv
// Shared definitions for the block-RAM extreme-value scanner: FSM state encodings and
// compare-mode constants.
package scan_extreme_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/extreme_cmp.sv
// Combinational comparator: asserts take_b when candidate b strictly improves on current a,
// for max or min, signed or unsigned.
module extreme_cmp
  import scan_extreme_engine_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode_min,
  input  logic              is_signed,
  output logic              take_b
);

  // One extra bit lets a single signed compare cover both number formats.
  logic signed [DATA_W:0] ax;
  logic signed [DATA_W:0] bx;

  always_comb begin
    ax     = {is_signed & a[DATA_W-1], a};
    bx     = {is_signed & b[DATA_W-1], b};
    take_b = (mode_min == MODE_MIN) ? (bx < ax) : (bx > ax);
  end

endmodule

// File: rtl/scan_extreme_engine.sv
// Scans n consecutive RAM words from startaddr (wrapping) and reports the max/min word and
// its address, with a start/done handshake and a configurable RAM read latency.
module scan_extreme_engine
  import scan_extreme_engine_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] startaddr,
  input  logic [ADDR_W-1:0] n,
  input  logic              mode_min,
  input  logic              is_signed,
  output logic [ADDR_W-1:0] addra,
  output logic              ena,
  input  logic [DATA_W-1:0] douta,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] result_idx,
  output logic              empty
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] count;
  logic              mode_min_l;
  logic              is_signed_l;

  logic [RD_LAT-1:0] vld_p;
  logic [ADDR_W-1:0] addr_p [RD_LAT];

  logic [DATA_W-1:0] acc;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_have;
  logic [DATA_W-1:0] acc_nxt;
  logic [ADDR_W-1:0] idx_nxt;
  logic              take_b;
  logic              hit;
  logic              pending;
  logic              accept;

  extreme_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a        (acc),
    .b        (douta),
    .mode_min (mode_min_l),
    .is_signed(is_signed_l),
    .take_b   (take_b)
  );

  assign accept = (state == S_IDLE) && start;
  assign ena    = (state == S_ISSUE);
  assign addra  = ena ? (base + cnt) : '0;
  assign busy   = (state == S_ISSUE) || (state == S_DRAIN);
  assign done   = (state == S_DONE);

  // Tags still short of the last stage mean data is yet to arrive.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pending = pending | vld_p[i];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (n == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if ((cnt + ADDR_W'(1)) == count) state_nxt = S_DRAIN;
      S_DRAIN: if (!pending) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read-return stage: first word loads unconditionally, later ones only on strict improvement.
  always_comb begin
    hit     = vld_p[RD_LAT-1] && (!acc_have || take_b);
    acc_nxt = hit ? douta : acc;
    idx_nxt = hit ? addr_p[RD_LAT-1] : acc_idx;
  end

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state      <= S_IDLE;
      vld_p      <= '0;
      acc_have   <= 1'b0;
      result     <= '0;
      result_idx <= '0;
      empty      <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld_p[0] <= ena;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      if (accept) acc_have <= 1'b0;
      else if (hit) acc_have <= 1'b1;
      if (state_nxt == S_DONE) begin
        if (state == S_IDLE) begin
          result     <= '0;
          result_idx <= '0;
          empty      <= 1'b1;
        end else begin
          result     <= acc_nxt;
          result_idx <= idx_nxt;
          empty      <= 1'b0;
        end
      end
    end
  end

  // Issue stage: scan parameters, address counter and the address tags riding with reads.
  always_ff @(posedge mclk) begin
    if (accept) begin
      base        <= startaddr;
      count       <= n;
      mode_min_l  <= mode_min;
      is_signed_l <= is_signed;
      cnt         <= '0;
    end else if (state == S_ISSUE) begin
      cnt <= cnt + ADDR_W'(1);
    end
    addr_p[0] <= addra;
    for (int i = 1; i < RD_LAT; i++) addr_p[i] <= addr_p[i-1];
    acc     <= acc_nxt;
    acc_idx <= idx_nxt;
  end

endmodule

// File: tb/tb_scan_extreme_engine.sv
// Bench for scan_extreme_engine: two instances (read latency 1 and 2) share stimulus; a
// per-instance scoreboard checks address issue, done timing and results.
module tb_scan_extreme_engine;

  typedef struct {
    logic [7:0]  sa;
    logic [7:0]  n;
    logic        mm;
    logic        sg;
    logic [15:0] res;
    logic [7:0]  idx;
    logic        emp;
  } vec_t;

  typedef struct {
    int          sc;
    logic [7:0]  sa;
    logic [7:0]  n;
    logic [15:0] res;
    logic [7:0]  idx;
    logic        emp;
  } sb_t;

  logic        mclk;
  logic        reset;
  logic        start;
  logic [7:0]  startaddr;
  logic [7:0]  n;
  logic        mode_min;
  logic        is_signed;

  logic [7:0]  addra1, addra2;
  logic        ena1, ena2;
  logic [15:0] douta1, douta2, rd2a;
  logic        busy1, busy2, done1, done2, empty1, empty2;
  logic [15:0] result1, result2;
  logic [7:0]  idx1, idx2;

  logic [15:0] mem [256];
  vec_t        vt [14];
  sb_t         q0 [$];
  sb_t         q1 [$];
  int          issued [2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  scan_extreme_engine #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1)) dut1 (
    .mclk(mclk), .reset(reset), .start(start), .startaddr(startaddr), .n(n),
    .mode_min(mode_min), .is_signed(is_signed), .addra(addra1), .ena(ena1),
    .douta(douta1), .busy(busy1), .done(done1), .result(result1),
    .result_idx(idx1), .empty(empty1)
  );

  scan_extreme_engine #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2)) dut2 (
    .mclk(mclk), .reset(reset), .start(start), .startaddr(startaddr), .n(n),
    .mode_min(mode_min), .is_signed(is_signed), .addra(addra2), .ena(ena2),
    .douta(douta2), .busy(busy2), .done(done2), .result(result2),
    .result_idx(idx2), .empty(empty2)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  always @(posedge mclk) cyc <= cyc + 1;

  // RAM models; reads without ena return junk so stray samples show up.
  always @(posedge mclk) begin
    douta1 <= ena1 ? mem[addra1] : 16'hDEAD;
    rd2a   <= ena2 ? mem[addra2] : 16'hDEAD;
    douta2 <= rd2a;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event with no expectation queued (cycle %0d)", nm, cyc);
  endtask

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic mon(input int k, input logic e, input logic [7:0] a, input logic d,
                     input logic b, input logic [15:0] r, input logic [7:0] ix,
                     input logic em);
    sb_t        s;
    int         sz;
    int         lat;
    logic [7:0] ea;
    s   = '{0, 8'd0, 8'd0, 16'd0, 8'd0, 1'b0};
    sz  = (k == 0) ? q0.size() : q1.size();
    lat = (k == 0) ? 1 : 2;
    if (sz > 0) s = (k == 0) ? q0[0] : q1[0];
    if (e) begin
      if (sz == 0) fail(k == 0 ? "ena_unexpected_lat1" : "ena_unexpected_lat2");
      else begin
        ea = s.sa + 8'(issued[k]);
        chk(k == 0 ? "addra_lat1" : "addra_lat2", a, ea);
        issued[k]++;
      end
    end
    if (d) begin
      if (sz == 0) fail(k == 0 ? "done_unexpected_lat1" : "done_unexpected_lat2");
      else begin
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        chk(k == 0 ? "done_cycle_lat1" : "done_cycle_lat2", cyc,
            s.sc + ((s.n == 0) ? 1 : (int'(s.n) + lat + 1)));
        chk(k == 0 ? "result_lat1" : "result_lat2", r, s.res);
        chk(k == 0 ? "result_idx_lat1" : "result_idx_lat2", ix, s.idx);
        chk(k == 0 ? "empty_lat1" : "empty_lat2", em, s.emp);
        chk(k == 0 ? "addr_count_lat1" : "addr_count_lat2", issued[k], s.n);
        chk(k == 0 ? "busy_at_done_lat1" : "busy_at_done_lat2", b, 1'b0);
        issued[k] = 0;
      end
    end
  endtask

  always @(negedge mclk) begin
    if (reset) begin
      mon(0, ena1, addra1, done1, busy1, result1, idx1, empty1);
      mon(1, ena2, addra2, done2, busy2, result2, idx2, empty2);
    end
  end

  task automatic chk_reset_outputs;
    chk("rst_addra_lat1", addra1, 0);   chk("rst_addra_lat2", addra2, 0);
    chk("rst_ena_lat1", ena1, 0);       chk("rst_ena_lat2", ena2, 0);
    chk("rst_busy_lat1", busy1, 0);     chk("rst_busy_lat2", busy2, 0);
    chk("rst_done_lat1", done1, 0);     chk("rst_done_lat2", done2, 0);
    chk("rst_result_lat1", result1, 0); chk("rst_result_lat2", result2, 0);
    chk("rst_idx_lat1", idx1, 0);       chk("rst_idx_lat2", idx2, 0);
    chk("rst_empty_lat1", empty1, 0);   chk("rst_empty_lat2", empty2, 0);
  endtask

  task automatic drive_start(input vec_t v);
    sb_t s;
    start     = 1'b1;
    startaddr = v.sa;
    n         = v.n;
    mode_min  = v.mm;
    is_signed = v.sg;
    s = '{cyc, v.sa, v.n, v.res, v.idx, v.emp};
    q0.push_back(s);
    q1.push_back(s);
    tick();
    start     = 1'b0;
    startaddr = 8'($urandom);
    n         = 8'($urandom);
    mode_min  = 1'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick();
    end
    chk("scan_completion", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic run_scan(input vec_t v);
    drive_start(v);
    chk("busy_after_start_lat1", busy1, v.n != 0);
    chk("busy_after_start_lat2", busy2, v.n != 0);
    wait_idle();
    tick();
    chk("held_result_lat1", result1, v.res);
    chk("held_result_lat2", result2, v.res);
    chk("held_idx_lat1", idx1, v.idx);
    chk("held_idx_lat2", idx2, v.idx);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    startaddr = 8'd0;
    n         = 8'd0;
    mode_min  = 1'b0;
    is_signed = 1'b0;
    issued    = '{0, 0};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'd5; mem[1] = 16'd9; mem[2] = 16'd3; mem[3] = 16'd9;
    mem[4] = 16'd1; mem[5] = 16'h8000; mem[6] = 16'd7; mem[7] = 16'd2;
    mem[254] = 16'h0011; mem[255] = 16'h0F00;

    //          sa      n       min   sgn   result      idx     empty
    vt[0]  = '{8'd0,   8'd2,   1'b0, 1'b0, 16'd9,      8'd1,   1'b0};
    vt[1]  = '{8'd1,   8'd3,   1'b0, 1'b0, 16'd9,      8'd1,   1'b0};
    vt[2]  = '{8'd3,   8'd4,   1'b0, 1'b0, 16'h8000,   8'd5,   1'b0};
    vt[3]  = '{8'd3,   8'd4,   1'b0, 1'b1, 16'd9,      8'd3,   1'b0};
    vt[4]  = '{8'd3,   8'd4,   1'b1, 1'b1, 16'h8000,   8'd5,   1'b0};
    vt[5]  = '{8'd254, 8'd4,   1'b0, 1'b0, 16'h0F00,   8'd255, 1'b0};
    vt[6]  = '{8'd0,   8'd0,   1'b0, 1'b0, 16'd0,      8'd0,   1'b1};
    vt[7]  = '{8'd0,   8'd8,   1'b1, 1'b0, 16'd1,      8'd4,   1'b0};
    vt[8]  = '{8'd3,   8'd4,   1'b1, 1'b0, 16'd1,      8'd4,   1'b0};
    vt[9]  = '{8'd7,   8'd1,   1'b0, 1'b1, 16'd2,      8'd7,   1'b0};
    vt[10] = '{8'd8,   8'd250, 1'b0, 1'b0, 16'h0F00,   8'd255, 1'b0};
    vt[11] = '{8'd8,   8'd250, 1'b1, 1'b0, 16'd0,      8'd8,   1'b0};
    vt[12] = '{8'd0,   8'd8,   1'b0, 1'b1, 16'd9,      8'd1,   1'b0};
    vt[13] = '{8'd255, 8'd3,   1'b1, 1'b1, 16'd5,      8'd0,   1'b0};

    repeat (3) tick();
    chk_reset_outputs();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) run_scan(vt[i]);

    // start pulses while busy must be ignored: only one done per instance
    drive_start(vt[2]);
    tick();
    start = 1'b1; startaddr = 8'd254; n = 8'd1; mode_min = 1'b0; is_signed = 1'b0;
    repeat (2) tick();
    start = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("ignored_start_result_lat1", result1, 16'h8000);
    chk("ignored_start_result_lat2", result2, 16'h8000);

    // reset mid-ISSUE aborts the scan with no done
    drive_start(vt[7]);
    repeat (2) tick();
    chk("mid_scan_busy_lat1", busy1, 1);
    reset = 1'b0;
    tick();
    chk_reset_outputs();
    q0.delete();
    q1.delete();
    issued = '{0, 0};
    reset = 1'b1;
    repeat (12) tick();
    run_scan(vt[13]);
    run_scan(vt[5]);

    repeat (4) tick();
    chk("no_leftover_expectations", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
